// File: rtl/modc_seq.sv
// Modulo-N counter sequencer: accepts a (modulus, repeat) job, counts 0..N-1
// for the requested number of wraps, then pulses done for one cycle.
module modc_seq #(
    parameter int unsigned CW = 4,
    parameter int unsigned RW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_mod,
    input  logic [RW-1:0] cfg_rep,
    input  logic          en,
    input  logic          abort,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic [RW-1:0] wraps_left,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] nm1;
    logic          at_top;
    logic          step;

    assign at_top = (cnt == nm1);
    assign step   = (state == S_RUN) && en && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cfg_valid) begin
                    state_nxt = (cfg_rep != RW'(0)) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (en && at_top && (wraps_left == RW'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wrap      = 1'b0;
        case (state)
            S_IDLE: cfg_ready = 1'b1;
            S_RUN: begin
                busy = 1'b1;
                wrap = step && at_top;
            end
            S_DONE:  done = 1'b1;
            default: cfg_ready = 1'b0;
        endcase
    end

    // Count / repeat datapath; the modulus is latched only on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= CW'(0);
            wraps_left <= RW'(0);
            nm1        <= CW'(0);
        end else begin
            if (state == S_IDLE && cfg_valid) begin
                nm1        <= (cfg_mod <= CW'(1)) ? CW'(0) : CW'(cfg_mod - CW'(1));
                wraps_left <= cfg_rep;
                cnt        <= CW'(0);
            end else if (state == S_RUN && abort) begin
                cnt        <= CW'(0);
                wraps_left <= RW'(0);
            end else if (step) begin
                if (at_top) begin
                    cnt        <= CW'(0);
                    wraps_left <= RW'(wraps_left - RW'(1));
                end else begin
                    cnt <= CW'(cnt + CW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_modc_seq.sv
// Bench for modc_seq: job-level reference model checked every cycle, plus
// directed scenarios with hand-computed latencies and wrap counts.
module tb_modc_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_mod = 4'd0;
    logic [7:0] cfg_rep = 8'd0;
    logic       en = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cnt;
    logic       wrap;
    logic [7:0] wraps_left;
    logic       busy;
    logic       done;

    modc_seq #(.CW(4), .RW(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mod(cfg_mod), .cfg_rep(cfg_rep), .en(en), .abort(abort),
        .cnt(cnt), .wrap(wrap), .wraps_left(wraps_left), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a job is a period and a number of periods left.
    bit m_running = 0;
    bit m_finish  = 0;
    int m_pos     = 0;
    int m_left    = 0;
    int m_period  = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running = 0; m_finish = 0; m_pos = 0; m_left = 0; m_period = 1;
        end else if (m_finish) begin
            m_finish = 0;
        end else if (m_running) begin
            if (abort) begin
                m_running = 0; m_pos = 0; m_left = 0;
            end else if (en) begin
                m_pos = (m_pos + 1) % m_period;
                if (m_pos == 0) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_running = 0;
                        m_finish  = 1;
                    end
                end
            end
        end else if (cfg_valid) begin
            m_period = (int'(cfg_mod) < 2) ? 1 : int'(cfg_mod);
            m_left   = int'(cfg_rep);
            m_pos    = 0;
            if (cfg_rep == 8'd0) m_finish = 1;
            else                 m_running = 1;
        end
    end

    // Event monitor for the directed latency checks.
    int cyc = 0;
    int n_acc = 0, first_acc = 0, last_acc = 0;
    int n_done = 0, done_cyc = 0;
    int n_wrap = 0, first_wrap = 0, last_wrap = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("cnt", int'(cnt), m_pos);
            chk("wraps_left", int'(wraps_left), m_left);
            chk("busy", int'(busy), int'(m_running));
            chk("done", int'(done), int'(m_finish));
            chk("cfg_ready", int'(cfg_ready), int'(!m_running && !m_finish));
            chk("wrap", int'(wrap),
                int'(m_running && en && !abort && ((m_pos + 1) % m_period == 0)));
            if (cfg_valid && cfg_ready) begin
                if (n_acc == 0) first_acc = cyc;
                last_acc = cyc;
                n_acc++;
            end
            if (wrap) begin
                if (n_wrap == 0) first_wrap = cyc;
                last_wrap = cyc;
                n_wrap++;
            end
            if (done) begin
                done_cyc = cyc;
                n_done++;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_acc = 0; n_done = 0; n_wrap = 0;
    endtask

    task automatic start_job(input int md, input int rp);
        cfg_mod   = 4'(md);
        cfg_rep   = 8'(rp);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        chk({name, "_done_seen"}, (n_done > 0) ? 1 : 0, 1);
    endtask

    task automatic wait_cnt(input int v, input int wl, input int budget);
        int k = 0;
        while (!(int'(cnt) == v && int'(wraps_left) == wl) && k < budget) begin
            tick();
            k++;
        end
        chk("wait_cnt_reached", (k < budget) ? 1 : 0, 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(cnt), 0);
        tick();
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // Basic run: mod 8, rep 2
        clr();
        start_job(8, 2);
        wait_done("basic", 40);
        chk("basic_latency", done_cyc - first_acc, 17);
        chk("basic_wraps", n_wrap, 2);
        chk("basic_wrap_spacing", last_wrap - first_wrap, 8);
        tick();
        chk("basic_ready_after", int'(cfg_ready), 1);
        chk("basic_one_done", n_done, 1);

        // Pause at cnt=2 for 3 cycles: mod 4, rep 1
        clr();
        start_job(4, 1);
        tick();
        tick();
        chk("pause_cnt_at_drop", int'(cnt), 2);
        en = 1'b0;
        repeat (3) tick();
        chk("pause_cnt_held", int'(cnt), 2);
        en = 1'b1;
        wait_done("pause", 20);
        chk("pause_latency", done_cyc - first_acc, 8);
        chk("pause_wraps", n_wrap, 1);
        tick();

        // Modulus 1, three repeats: wrap on consecutive cycles
        clr();
        start_job(1, 3);
        wait_done("mod1", 20);
        chk("mod1_wraps", n_wrap, 3);
        chk("mod1_consecutive", last_wrap - first_wrap, 2);
        chk("mod1_latency", done_cyc - first_acc, 4);
        tick();

        // Zero-repeat job completes immediately
        clr();
        start_job(5, 0);
        wait_done("rep0", 10);
        chk("rep0_latency", done_cyc - first_acc, 1);
        chk("rep0_wraps", n_wrap, 0);
        tick();

        // Abort at cnt=7 with one wrap left
        clr();
        start_job(8, 4);
        wait_cnt(7, 1, 60);
        abort = 1'b1;
        #3;
        chk("abort_wrap_masked", int'(wrap), 0);
        tick();
        abort = 1'b0;
        chk("abort_ready", int'(cfg_ready), 1);
        chk("abort_cnt", int'(cnt), 0);
        chk("abort_wl", int'(wraps_left), 0);
        repeat (3) tick();
        chk("abort_no_done", n_done, 0);
        chk("abort_wraps", n_wrap, 3);

        // Asynchronous reset mid-run at cnt=5
        clr();
        start_job(8, 2);
        wait_cnt(5, 2, 20);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt", int'(cnt), 0);
        chk("arst_wl", int'(wraps_left), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(cfg_ready), 1);
        chk("arst_done", int'(done), 0);
        chk("arst_wrap", int'(wrap), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_no_done", n_done, 0);
        clr();
        start_job(3, 1);
        chk("arst_new_cnt", int'(cnt), 0);
        wait_done("arst_new", 20);
        chk("arst_new_latency", done_cyc - first_acc, 4);
        tick();

        // Back-to-back: cfg_valid held, second job queued behind the first
        clr();
        cfg_mod   = 4'd3;
        cfg_rep   = 8'd1;
        cfg_valid = 1'b1;
        tick();
        cfg_mod = 4'd2;
        cfg_rep = 8'd1;
        begin
            int k = 0;
            while (n_acc < 2 && k < 20) begin
                tick();
                k++;
            end
        end
        cfg_valid = 1'b0;
        chk("b2b_accepts", n_acc, 2);
        chk("b2b_first_done", done_cyc - first_acc, 4);
        chk("b2b_gap", last_acc - done_cyc, 1);
        n_done = 0;
        wait_done("b2b_second", 20);
        chk("b2b_second_latency", done_cyc - last_acc, 3);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/modc_seq.md
MODC_SEQ -- requirements
Module: modc_seq

Interface
REQ-001 Parameter CW, default 4: width of count value and modulus.
REQ-002 Parameter RW, default 8: width of repeat count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_valid  input  1  job request; qualifies cfg_mod and cfg_rep.
REQ-006 cfg_ready  output  1  block can accept a job.
REQ-007 cfg_mod  input  CW  modulus N; count runs 0..N-1.
REQ-008 cfg_rep  input  RW  number of full count cycles (wraps) to run.
REQ-009 en  input  1  run enable; low pauses the count.
REQ-010 abort  input  1  cancel the running job.
REQ-011 cnt  output  CW  current count value.
REQ-012 wrap  output  1  count wraps from N-1 to 0 on this clock edge.
REQ-013 wraps_left  output  RW  wraps remaining in the current job.
REQ-014 busy  output  1  job in progress (state RUN).
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 States SHALL be IDLE, RUN and DONE, held in a registered state variable.
REQ-017 cfg_ready SHALL be 1 exactly when state==IDLE; busy SHALL be 1 exactly when state==RUN; done SHALL be 1 exactly when state==DONE.
REQ-018 Handshake: on an edge with state==IDLE and cfg_valid==1, the block SHALL latch Nm1 = (cfg_mod<=1 ? 0 : cfg_mod-1), load wraps_left=cfg_rep, and set cnt=0.
REQ-019 On that handshake edge, the next state SHALL be RUN if cfg_rep!=0, else DONE (zero-repeat job completes with no wrap).
REQ-020 cfg_valid outside IDLE SHALL be ignored; latched Nm1 and wraps_left SHALL NOT change while RUN.
REQ-021 RUN, en==0, abort==0: cnt, wraps_left and state SHALL hold; wrap SHALL be 0.
REQ-022 RUN, en==1, abort==0, cnt!=Nm1: cnt SHALL increment by 1 on the edge.
REQ-023 RUN, en==1, abort==0, cnt==Nm1: wrap SHALL be 1 combinationally that cycle, and on the edge cnt SHALL become 0 and wraps_left SHALL decrement by 1.
REQ-024 If REQ-023 applies and wraps_left==1, the next state SHALL be DONE; otherwise it SHALL remain RUN.
REQ-025 Modulus 0 or 1 SHALL give Nm1=0: cnt stays 0 and wrap is asserted every enabled RUN cycle.
REQ-026 Abort in RUN SHALL take priority over en and wrap: wrap=0 that cycle, next state IDLE, cnt=0, wraps_left=0, and no done pulse.
REQ-027 Abort in IDLE or DONE SHALL be ignored.
REQ-028 DONE SHALL last exactly one cycle, then return to IDLE; cnt SHALL be 0 throughout DONE.
REQ-029 Arithmetic SHALL be unsigned; cnt SHALL never exceed Nm1, and wraps_left SHALL never underflow.
REQ-030 A new job SHALL be acceptable on the first IDLE cycle after DONE, giving a minimum of 2 cycles between the last wrap and the next accept.

Reset
REQ-031 rst==1 SHALL immediately, without a clock edge, force state=IDLE, cnt=0, wraps_left=0, latched Nm1=0, wrap=0, done=0, busy=0, cfg_ready=1.
REQ-032 Reset asserted mid-job SHALL discard the job with no done pulse; operation SHALL resume from IDLE on the first edge after rst deasserts.

Verification
REQ-033 Basic run: accept cfg_mod=8, cfg_rep=2, en=1 constantly -> cnt 0..7,0..7; wrap high twice, 8 cycles apart; wraps_left 2->1->0; done pulses once, 17 cycles after accept; cfg_ready back the next cycle.
REQ-034 Pause: cfg_mod=4, cfg_rep=1, drop en for 3 cycles at cnt=2 -> cnt holds at 2, no wrap; done arrives 3 cycles later than the unpaused run.
REQ-035 Degenerate jobs: cfg_mod=1, cfg_rep=3 -> wrap high 3 consecutive cycles with cnt=0, then done; cfg_mod=5, cfg_rep=0 -> DONE the cycle after accept, no wrap.
REQ-036 Abort: cfg_mod=8, cfg_rep=4, abort at cnt=7 while wraps_left=1 -> wrap=0 and done never asserts; IDLE, cnt=0, wraps_left=0 next cycle.
REQ-037 Async reset: assert rst between clock edges mid-RUN (cnt=5) -> outputs reach reset values before the next edge; a new job after release runs from cnt=0.
REQ-038 Back-to-back: cfg_valid held high with a new job queued behind a running one -> ignored during RUN/DONE; accepted on the IDLE cycle following done.
